instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache_pkg.sv | 9 +
 rtl/instr_cache_if.sv | 23 ++
 rtl/icache_array.sv | 31 +++
 rtl/instr_cache.sv | 113 +++++++++++
 tb/tb_instr_cache.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared FSM encoding and default geometry for the instruction cache
package instr_cache_pkg;
  localparam int ICACHE_INDEX_BITS = 6;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MISS    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;
endpackage

// File: rtl/instr_cache_if.sv
// instr_cache_if: fetch-stage and memory-controller signals of the instruction cache
interface instr_cache_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_clear;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_instr;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  modport master (
    output if_req, if_pc, if_clear, mem_valid, mem_instr,
    input  if_ready, if_valid, if_instr, mem_req, mem_addr, hit_cnt, miss_cnt
  );
  modport slave (
    input  if_req, if_pc, if_clear, mem_valid, mem_instr,
    output if_ready, if_valid, if_instr, mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: direct-mapped tag/valid/data store, one write port, async read, valid bits cleared on rst
module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0]         data_mem [LINES];
  always_comb valid_d = we ? valid_q | (LINES'(1) << wr_idx) : valid_q;
  always_ff @(posedge clk) valid_q <= rst ? '0 : valid_d;
  always_ff @(posedge clk)
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, one word per line instruction cache with blocking miss handling.
// Define ICACHE_STATS_EN to build the hit/miss statistics counters.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  instr_cache_if.slave bus
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d, if_valid_q, if_valid_d;
  logic [31:0]         mem_addr_q, mem_addr_d, if_instr_q, if_instr_d;
  logic                we, rd_valid, hit, accept;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_data;
  icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk,
    .rst,
    .we,
    .wr_idx  (mem_addr_q[INDEX_BITS+1:2]),
    .wr_tag  (mem_addr_q[31:INDEX_BITS+2]),
    .wr_data (bus.mem_instr),
    .rd_idx  (bus.if_pc[INDEX_BITS+1:2]),
    .rd_valid,
    .rd_tag,
    .rd_data
  );
  assign hit    = rd_valid && rd_tag == bus.if_pc[31:INDEX_BITS+2];
  assign accept = rdy && state_q == S_IDLE && bus.if_req && !bus.if_clear;
  // mem_addr_q doubles as the latched miss address used for the fill
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_valid_d = rdy ? 1'b0 : if_valid_q;
    if_instr_d = if_instr_q;
    we         = 1'b0;
    if (rdy)
      case (state_q)
        S_IDLE:
          if (accept) begin
            if (hit) begin
              if_valid_d = 1'b1;
              if_instr_d = rd_data;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = bus.if_pc & ~32'h3;
              state_d    = S_MISS;
            end
          end
        S_MISS:
          if (bus.mem_valid) begin
            we         = 1'b1;
            mem_req_d  = 1'b0;
            if_valid_d = !bus.if_clear;
            if_instr_d = bus.if_clear ? if_instr_q : bus.mem_instr;
            state_d    = S_IDLE;
          end else if (bus.if_clear) begin
            state_d = S_DISCARD;
          end
        S_DISCARD:
          if (bus.mem_valid) begin
            we        = 1'b1;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
    end
  assign bus.if_ready = state_q == S_IDLE && !bus.if_clear;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, accept && hit};
    miss_cnt_d = miss_cnt_q + {31'd0, accept && !hit};
  end
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed scoreboard bench for instr_cache (counter checks follow ICACHE_STATS_EN)
module tb_instr_cache;
  import instr_cache_pkg::*;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk, rst, rdy;
  instr_cache_if bus ();
  instr_cache dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  logic [31:0] sb[$];
  logic [31:0] mon_exp;
  int n_chk, n_fail, exp_hit, exp_miss;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // monitor: every if_valid pulse must match the oldest queued expectation
  always @(negedge clk)
    if (!rst && bus.if_valid === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_if_valid: got instr %h, expected no pulse", bus.if_instr);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.if_instr !== mon_exp) begin
          n_fail++;
          $display("FAIL if_instr: got %h, expected %h", bus.if_instr, mon_exp);
        end
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic check_cnt;
    check("hit_cnt", bus.hit_cnt, STATS ? exp_hit : 0);
    check("miss_cnt", bus.miss_cnt, STATS ? exp_miss : 0);
  endtask
  task automatic issue(input logic [31:0] pc);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    tick;
    bus.if_req = 1'b0;
  endtask
  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] data);
    sb.push_back(data);
    exp_hit++;
    issue(pc);
    check("hit_no_mem_req", bus.mem_req, 0);
  endtask
  task automatic fetch_miss(input logic [31:0] pc);
    exp_miss++;
    issue(pc);
    check("miss_mem_req", bus.mem_req, 1);
    check("miss_mem_addr", bus.mem_addr, pc & ~32'h3);
    check("miss_not_ready", bus.if_ready, 0);
  endtask
  task automatic serve(input logic [31:0] pc, input int delay, input logic [31:0] data, input bit deliver);
    for (int i = 0; i < delay; i++) begin
      check("wait_mem_req", bus.mem_req, 1);
      check("wait_mem_addr", bus.mem_addr, pc & ~32'h3);
      tick;
    end
    if (deliver) sb.push_back(data);
    bus.mem_valid = 1'b1;
    bus.mem_instr = data;
    tick;
    bus.mem_valid = 1'b0;
    check("fill_mem_req_drop", bus.mem_req, 0);
    check("fill_ready", bus.if_ready, 1);
  endtask
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;
    bus.if_pc = '0;
    bus.if_clear = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = '0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_ready", bus.if_ready, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_if_instr", bus.if_instr, 0);
    check_cnt;
    // cold miss then hit
    fetch_miss(32'h0000_1004);
    serve(32'h0000_1004, 3, 32'h00A0_0093, 1);
    check_cnt;
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
    tick;
    check_cnt;
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
    // conflicting tag on the same index evicts the line
    fetch_miss(32'h0000_1104);
    serve(32'h0000_1104, 0, 32'h1111_1111, 1);
    fetch_hit(32'h0000_1104, 32'h1111_1111);
    fetch_miss(32'h0000_1004);
    serve(32'h0000_1004, 2, 32'h00A0_0093, 1);
    fetch_hit(32'h0000_1004, 32'h00A0_0093);
    tick;
    check_cnt;
    // clear in IDLE kills the request
    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_1004;
    bus.if_clear = 1'b1;
    #1;
    check("clear_idle_ready", bus.if_ready, 0);
    tick;
    bus.if_req = 1'b0;
    bus.if_clear = 1'b0;
    tick;
    check_cnt;
    // clear during miss: fill completes silently
    fetch_miss(32'h0000_2008);
    tick;
    bus.if_clear = 1'b1;
    tick;
    bus.if_clear = 1'b0;
    check("discard_mem_req", bus.mem_req, 1);
    serve(32'h0000_2008, 5, 32'hDEAD_BEEF, 0);
    check("discard_instr_hold", bus.if_instr, 32'h00A0_0093);
    fetch_hit(32'h0000_2008, 32'hDEAD_BEEF);
    // clear and mem_valid in the same cycle
    fetch_miss(32'h0000_300C);
    bus.if_clear = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_instr = 32'h1234_5678;
    tick;
    bus.if_clear = 1'b0;
    bus.mem_valid = 1'b0;
    check("clr_fill_mem_req", bus.mem_req, 0);
    fetch_hit(32'h0000_300C, 32'h1234_5678);
    tick;
    check_cnt;
    // slow memory with rdy toggling and ignored requests
    fetch_miss(32'h0000_4010);
    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_5000;
    for (int i = 0; i < 40; i++) begin
      rdy = (i % 3) != 0;
      check("slow_mem_req", bus.mem_req, 1);
      check("slow_mem_addr", bus.mem_addr, 32'h0000_4010);
      tick;
    end
    rdy = 1'b1;
    bus.if_req = 1'b0;
    serve(32'h0000_4010, 0, 32'hCAFE_F00D, 1);
    fetch_hit(32'h0000_4010, 32'hCAFE_F00D);
    tick;
    check_cnt;
    // reset mid-miss, then a stale fill
    fetch_miss(32'h0000_6000);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_hit = 0;
    exp_miss = 0;
    check("rst2_mem_req", bus.mem_req, 0);
    check("rst2_ready", bus.if_ready, 1);
    check("rst2_if_instr", bus.if_instr, 0);
    check_cnt;
    bus.mem_valid = 1'b1;
    bus.mem_instr = 32'hBAD0_BAD0;
    tick;
    bus.mem_valid = 1'b0;
    check("stale_mem_req", bus.mem_req, 0);
    check("stale_ready", bus.if_ready, 1);
    fetch_miss(32'h0000_0000);
    serve(32'h0000_0000, 1, 32'h0000_0013, 1);
    fetch_miss(32'h0000_1004);
    serve(32'h0000_1004, 1, 32'h00A0_0093, 1);
    fetch_miss(32'h0000_300C);
    serve(32'h0000_300C, 0, 32'h5555_AAAA, 1);
    fetch_hit(32'h0000_300C, 32'h5555_AAAA);
    tick;
    tick;
    check_cnt;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
